// File: rtl/sistema_button_pio.sv
`default_nettype none
// ============================================================================
// Module  : sistema_button_pio
// Brief   : Debounced button/switch PIO with edge capture, IRQ mask and
//           an Avalon-MM slave register interface.
// Revision: 1.0
// ============================================================================
module sistema_button_pio #(
   parameter int WIDTH           = 8,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int EDGE_TYPE       = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   localparam int              c_CW      = $clog2(DEBOUNCE_CYCLES);
   localparam logic [c_CW-1:0] c_CNT_MAX = c_CW'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] r_sync1;
   logic [WIDTH-1:0] r_sync2;
   logic [WIDTH-1:0] r_state;
   logic [WIDTH-1:0] r_mask;
   logic [WIDTH-1:0] r_edge;
   logic [WIDTH-1:0] w_state_nxt;
   logic [WIDTH-1:0] w_edge_evt;
   logic [WIDTH-1:0] w_clr;
   logic             w_wr;

   assign w_wr  = chipselect & ~write_n;
   assign w_clr = (w_wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= in_port;
         r_sync2 <= r_sync1;
      end
   end

   // Each bit accepts a new level only after DEBOUNCE_CYCLES consecutive
   // disagreeing samples; any agreeing sample restarts the count.
   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         logic [c_CW-1:0] r_cnt;
         logic            w_diff;

         assign w_diff         = r_sync2[i] ^ r_state[i];
         assign w_state_nxt[i] = (w_diff && r_cnt == c_CNT_MAX) ? r_sync2[i] : r_state[i];

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_cnt <= '0;
            end else if (!w_diff || r_cnt == c_CNT_MAX) begin
               r_cnt <= '0;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end
   endgenerate

   generate
      if (EDGE_TYPE == 0) begin : g_rise
         assign w_edge_evt = w_state_nxt & ~r_state;
      end else if (EDGE_TYPE == 1) begin : g_fall
         assign w_edge_evt = ~w_state_nxt & r_state;
      end else begin : g_any
         assign w_edge_evt = w_state_nxt ^ r_state;
      end
   endgenerate

   generate
      if (WIDTH < 32) begin : g_unused
         logic w_unused_wdata;
         assign w_unused_wdata = &{1'b0, writedata[31:WIDTH]};
      end
   endgenerate

   // New edges are OR-ed in after the clear so a coincident edge wins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= '0;
         r_mask  <= '0;
         r_edge  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_edge  <= (r_edge & ~w_clr) | w_edge_evt;
         if (w_wr && address == 2'd2) begin
            r_mask <= writedata[WIDTH-1:0];
         end
      end
   end

   always_comb begin
      readdata = 32'd0;
      case (address)
         2'd0:    readdata = 32'(r_state);
         2'd2:    readdata = 32'(r_mask);
         2'd3:    readdata = 32'(r_edge);
         default: readdata = 32'd0;
      endcase
   end

   assign irq = |(r_edge & r_mask);

endmodule
`default_nettype wire

// File: tb/tb_sistema_button_pio.sv
`default_nettype none
// Bench for sistema_button_pio: a rising-edge and an any-edge instance share
// stimulus; a sample-history model is compared every cycle plus literal checks.
module tb_sistema_button_pio;

   localparam int N = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [7:0]  in_port;
   logic [31:0] rd0, rd2;
   logic        irq0, irq2;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   sistema_button_pio #(.WIDTH(8), .DEBOUNCE_CYCLES(N), .EDGE_TYPE(0)) dut0 (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(rd0), .irq(irq0));

   sistema_button_pio #(.WIDTH(8), .DEBOUNCE_CYCLES(N), .EDGE_TYPE(2)) dut2 (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(rd2), .irq(irq2));

   // Model: hist[k] is the input sampled k edges ago. A bit flips once the
   // input, seen through the two-edge synchronizer, has shown the opposite
   // level on each of the last N edges.
   logic [7:0] hist [0:N+1];
   logic [7:0] m_state, m_mask, m_cap0, m_cap2;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k <= N + 1; k++) hist[k] = 8'h00;
         m_state = 8'h00; m_mask = 8'h00; m_cap0 = 8'h00; m_cap2 = 8'h00;
      end else begin
         logic [7:0] nxt, clr;
         for (int k = N + 1; k > 0; k--) hist[k] = hist[k-1];
         hist[0] = in_port;
         nxt = m_state;
         for (int b = 0; b < 8; b++) begin
            bit all_opp;
            all_opp = 1'b1;
            for (int k = 2; k <= N + 1; k++)
               if (hist[k][b] == m_state[b]) all_opp = 1'b0;
            if (all_opp) nxt[b] = ~m_state[b];
         end
         clr = (chipselect && !write_n && address == 2'd3) ? writedata[7:0] : 8'h00;
         m_cap0 = (m_cap0 & ~clr) | (nxt & ~m_state);
         m_cap2 = (m_cap2 & ~clr) | (nxt ^ m_state);
         if (chipselect && !write_n && address == 2'd2) m_mask = writedata[7:0];
         m_state = nxt;
      end
   end

   function automatic logic [31:0] exp_rd(input logic [1:0] a, input logic [7:0] cap);
      case (a)
         2'd0:    return {24'd0, m_state};
         2'd2:    return {24'd0, m_mask};
         2'd3:    return {24'd0, cap};
         default: return 32'd0;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("model_rd0", rd0, exp_rd(address, m_cap0));
      chk("model_rd2", rd2, exp_rd(address, m_cap2));
      chk("model_irq0", {31'd0, irq0}, {31'd0, |(m_cap0 & m_mask)});
      chk("model_irq2", {31'd0, irq2}, {31'd0, |(m_cap2 & m_mask)});
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      tick(1);
      chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
   endtask

   task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] e0,
                         input logic [31:0] e2);
      address = a;
      #1;
      chk({name, "_dut0"}, rd0, e0);
      chk({name, "_dut2"}, rd2, e2);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
      writedata = 32'd0; in_port = 8'h00;
      tick(2);
      rd_chk("reset_state", 2'd0, 32'h0, 32'h0);
      rd_chk("reset_cap", 2'd3, 32'h0, 32'h0);
      chk("reset_irq", {31'd0, irq0}, 32'h0);
      reset = 1'b0;
      tick(3);

      // Stable rise on bit 0: visible on edge 6, not edge 5
      address = 2'd0; in_port = 8'h01;
      tick(5);
      rd_chk("rise_edge5", 2'd0, 32'h00, 32'h00);
      tick(1);
      rd_chk("rise_edge6", 2'd0, 32'h01, 32'h01);
      rd_chk("rise_cap", 2'd3, 32'h01, 32'h01);
      wr(2'd3, 32'hFF);
      rd_chk("cap_cleared", 2'd3, 32'h00, 32'h00);

      // Bring bit 0 low (falling caught only by any-edge), then 3-clock glitch
      in_port = 8'h00;
      tick(8);
      rd_chk("fall_cap", 2'd3, 32'h00, 32'h01);
      wr(2'd3, 32'hFF);
      in_port = 8'h01;
      tick(3);
      in_port = 8'h00;
      tick(10);
      rd_chk("glitch_state", 2'd0, 32'h00, 32'h00);
      rd_chk("glitch_cap", 2'd3, 32'h00, 32'h00);

      // Masked interrupt on bit 0
      wr(2'd2, 32'h01);
      in_port = 8'h01;
      tick(5);
      chk("irq_edge5", {31'd0, irq0}, 32'h0);
      tick(1);
      chk("irq_edge6", {31'd0, irq0}, 32'h1);
      chk("irq2_edge6", {31'd0, irq2}, 32'h1);
      wr(2'd3, 32'h01);
      chk("irq_cleared", {31'd0, irq0}, 32'h0);
      rd_chk("mask_read", 2'd2, 32'h01, 32'h01);

      // Clear of bit 2 coincides with its rise: set wins
      in_port = 8'h05;
      tick(5);
      wr(2'd3, 32'h04);
      rd_chk("set_wins", 2'd3, 32'h04, 32'h04);
      wr(2'd3, 32'hFF);

      // Reset mid-debounce with counter at 2
      in_port = 8'h80;
      tick(4);
      reset = 1'b1;
      #1;
      rd_chk("rst_mid_state", 2'd0, 32'h0, 32'h0);
      rd_chk("rst_mid_mask", 2'd2, 32'h0, 32'h0);
      rd_chk("rst_mid_cap", 2'd3, 32'h0, 32'h0);
      chk("rst_mid_irq", {31'd0, irq0 | irq2}, 32'h0);
      tick(1);
      reset = 1'b0;
      address = 2'd0;
      tick(5);
      rd_chk("post_rst_edge5", 2'd0, 32'h00, 32'h00);
      tick(1);
      rd_chk("post_rst_edge6", 2'd0, 32'h80, 32'h80);
      rd_chk("post_rst_cap", 2'd3, 32'h80, 32'h80);

      // Any-edge capture on bit 3 rise and fall; address 1 reads zero
      wr(2'd3, 32'hFF);
      in_port = 8'h88;
      tick(6);
      rd_chk("b3_rise_cap", 2'd3, 32'h08, 32'h08);
      wr(2'd3, 32'hFF);
      in_port = 8'h80;
      tick(6);
      rd_chk("b3_fall_cap", 2'd3, 32'h00, 32'h08);
      wr(2'd1, 32'hFFFFFFFF);
      rd_chk("addr1_zero", 2'd1, 32'h0, 32'h0);
      tick(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
